dshot_rx: RTL and testbench

//  Receiver/decoder for 16-bit DShot frames, the inverse of DShotTx + DShotPacketEncoder.

---
 rtl/dshot_pkg.sv | 23 ++
 rtl/dshot_rx_if.sv | 34 +++
 rtl/dshot_rx_sync.sv | 38 +++
 rtl/dshot_rx.sv | 166 ++++++++++++++++
 tb/tb_dshot_rx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dshot_pkg.sv
// dshot_pkg
// Shared DShot definitions: frame geometry, receiver state encoding and the
// 4-bit frame checksum (shared with the packet encoder on the transmit side).
// No ports.
package dshot_pkg;

  localparam int DSHOT_FRAME_BITS = 16;
  localparam int DSHOT_CRC_BITS   = 4;
  localparam int DSHOT_CMD_BITS   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } dshot_state_t;

  // XOR of the three nibbles of {command, telemetryReq}.
  function automatic logic [DSHOT_CRC_BITS-1:0] dshot_crc(input logic [11:0] d);
    return d[11:8] ^ d[7:4] ^ d[3:0];
  endfunction

endpackage

// File: rtl/dshot_rx_if.sv
// dshot_rx_if
// Line input and decoded-frame outputs of the DShot receiver.
//   rxIn          raw DShot line (driven by master)
//   packet        last good frame {command, telemetryReq, crc}
//   command       packet[15:5]
//   telemetryReq  packet[4]
//   valid         1-cycle pulse, good frame latched
//   crcError      1-cycle pulse, 16 bits received with bad checksum
//   frameError    1-cycle pulse, malformed/partial frame discarded
//   busy          frame reception in progress
// Modports: master = line driver / frame consumer, slave = receiver.
interface dshot_rx_if;
  import dshot_pkg::*;

  logic                        rxIn;
  logic [DSHOT_FRAME_BITS-1:0] packet;
  logic [DSHOT_CMD_BITS-1:0]   command;
  logic                        telemetryReq;
  logic                        valid;
  logic                        crcError;
  logic                        frameError;
  logic                        busy;

  modport master (
    output rxIn,
    input  packet, command, telemetryReq, valid, crcError, frameError, busy
  );

  modport slave (
    input  rxIn,
    output packet, command, telemetryReq, valid, crcError, frameError, busy
  );

endinterface

// File: rtl/dshot_rx_sync.sv
// dshot_rx_sync
// Brings the asynchronous DShot line into the clock domain and detects edges.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   rx_in    raw line
//   rx_s     synchronized line (2 cycles after the pin)
//   rise     rx_s went 0->1 this cycle
//   fall     rx_s went 1->0 this cycle
module dshot_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic rx_in,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= rx_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rx_s = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/dshot_rx.sv
// dshot_rx
// DShot frame receiver: classifies each bit by its high time, assembles 16
// bits MSB first, checks the nibble-XOR checksum and latches good frames.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      dshot_rx_if.slave (rxIn in; packet/command/telemetryReq,
//            valid/crcError/frameError strobes and busy out)
module dshot_rx
  import dshot_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int MIN_HIGH_CLKS  = CLKS_PER_BIT / 8,
  parameter int FRAME_GAP_CLKS = 2 * CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset_n,
  dshot_rx_if.slave  bus
);

  localparam int CW = $clog2(FRAME_GAP_CLKS + 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH_CLKS);
  localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_C    = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] GAP_C    = CW'(FRAME_GAP_CLKS);
  localparam logic [CW-1:0] GAP_M1_C = CW'(FRAME_GAP_CLKS - 1);
  localparam logic [4:0]    LAST_BIT = 5'(DSHOT_FRAME_BITS - 1);

  logic rx_s, rise, fall;

  dshot_rx_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .rx_in   (bus.rxIn),
    .rx_s    (rx_s),
    .rise    (rise),
    .fall    (fall)
  );

  dshot_state_t                state_reg;
  logic [CW-1:0]               cnt_reg;
  logic [CW-1:0]               low_hold_reg;   // low count at the last rise, restored after a glitch
  logic [4:0]                  bit_cnt_reg;
  logic [DSHOT_FRAME_BITS-1:0] shift_reg;
  logic [DSHOT_FRAME_BITS-1:0] packet_reg;
  logic                        valid_reg;
  logic                        crc_err_reg;
  logic                        frame_err_reg;

  logic [CW-1:0]               cnt_inc;
  logic [CW:0]                 glitch_sum;
  logic [CW-1:0]               glitch_cnt;
  logic [DSHOT_FRAME_BITS-1:0] shift_next;
  logic                        crc_ok;

  always_comb begin
    cnt_inc    = (cnt_reg >= GAP_C) ? GAP_C : cnt_reg + ONE_C;
    // A rejected spike counts as low time so the frame gap timer keeps running.
    glitch_sum = {1'b0, low_hold_reg} + {1'b0, cnt_reg} + {1'b0, ONE_C};
    glitch_cnt = (glitch_sum >= {1'b0, GAP_C}) ? GAP_C : glitch_sum[CW-1:0];
    shift_next = {shift_reg[DSHOT_FRAME_BITS-2:0], (cnt_reg > HALF_C)};
    crc_ok     = (dshot_crc(shift_next[15:4]) == shift_next[3:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      low_hold_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      packet_reg    <= '0;
      valid_reg     <= 1'b0;
      crc_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      crc_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        // Wait for a full frame gap so reception never starts mid-frame.
        IDLE: begin
          bit_cnt_reg <= '0;
          if (rx_s) begin
            cnt_reg <= '0;
          end else if (cnt_reg >= GAP_M1_C) begin
            cnt_reg   <= '0;
            state_reg <= ARMED;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ARMED: begin
          bit_cnt_reg <= '0;
          if (rise) begin
            cnt_reg   <= ONE_C;
            state_reg <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            if (cnt_reg < MIN_C) begin
              if (bit_cnt_reg == 5'd0) begin
                cnt_reg   <= '0;
                state_reg <= ARMED;
              end else begin
                cnt_reg   <= glitch_cnt;
                state_reg <= LOW;
              end
            end else begin
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              cnt_reg     <= ONE_C;
              if (bit_cnt_reg == LAST_BIT) begin
                state_reg <= IDLE;
                if (crc_ok) begin
                  packet_reg <= shift_next;
                  valid_reg  <= 1'b1;
                end else begin
                  crc_err_reg <= 1'b1;
                end
              end else begin
                state_reg <= LOW;
              end
            end
          end else if (cnt_reg >= BIT_C) begin
            // Line held high longer than a whole bit period.
            frame_err_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            low_hold_reg <= cnt_reg;
            cnt_reg      <= ONE_C;
            state_reg    <= HIGH;
          end else if (cnt_inc >= GAP_C && bit_cnt_reg != 5'd0 &&
                       bit_cnt_reg <= LAST_BIT) begin
            frame_err_reg <= 1'b1;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            state_reg     <= ARMED;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.packet       = packet_reg;
  assign bus.command      = packet_reg[15:5];
  assign bus.telemetryReq = packet_reg[4];
  assign bus.valid        = valid_reg;
  assign bus.crcError     = crc_err_reg;
  assign bus.frameError   = frame_err_reg;
  assign bus.busy         = (state_reg == HIGH) || (state_reg == LOW);

endmodule

// File: tb/tb_dshot_rx.sv
// tb_dshot_rx
// Drives pulse-width-coded DShot frames into dshot_rx and checks every
// strobe against a queue of expected events.
module tb_dshot_rx;

  localparam int BITP     = 16;
  localparam int HI1      = 11;
  localparam int HI0      = 5;
  localparam int GAP_WAIT = 48;

  localparam int EV_VALID = 0;
  localparam int EV_CRC   = 1;
  localparam int EV_FRAME = 2;

  typedef struct {
    int          kind;
    logic [15:0] pkt;
  } exp_t;

  typedef struct {
    logic [15:0] frame;
    int          kind;
    logic [15:0] pkt;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  dshot_rx_if bus ();

  dshot_rx #(.CLKS_PER_BIT(BITP)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Independent frame builder: {cmd, tlm, checksum of the 12 payload bits}.
  function automatic logic [15:0] enc(input logic [10:0] cmd, input logic tlm);
    logic [11:0] v;
    logic [11:0] x;
    v = {cmd, tlm};
    x = v ^ (v >> 4) ^ (v >> 8);
    return {v, x[3:0]};
  endfunction

  // Scoreboard: every strobe must match the next queued expectation.
  always @(negedge clock) begin : monitor
    int   n;
    int   act_kind;
    exp_t e;
    if (reset_n === 1'b1) begin
      n = int'(bus.valid) + int'(bus.crcError) + int'(bus.frameError);
      if (n > 1) begin
        check("exclusive_strobes", 32'(n), 32'd1);
      end else if (n == 1) begin
        act_kind = bus.valid ? EV_VALID : (bus.crcError ? EV_CRC : EV_FRAME);
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(act_kind + 1), 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", 32'(act_kind), 32'(e.kind));
          check("packet", 32'(bus.packet), 32'(e.pkt));
          if (bus.valid) begin
            check("command", 32'(bus.command), 32'(e.pkt[15:5]));
            check("telemetryReq", 32'(bus.telemetryReq), 32'(e.pkt[4]));
          end
          $display("event kind=%0d packet=%04h", act_kind, bus.packet);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clock);
      bus.rxIn = v;
    end
  endtask

  // Sends the first nbits of f; glitch_bit >= 0 puts a 1-cycle spike in that bit's low phase.
  task automatic send_bits(input logic [15:0] f, input int nbits, input int glitch_bit);
    logic b;
    int   hi;
    for (int i = 0; i < nbits; i++) begin
      b  = f[15-i];
      hi = b ? HI1 : HI0;
      drive(1'b1, hi);
      if (i == glitch_bit) begin
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, BITP - hi - 5);
      end else begin
        drive(1'b0, BITP - hi);
      end
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] pkt);
    exp_t e;
    e.kind = kind;
    e.pkt  = pkt;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [15:0] f, input int kind, input logic [15:0] pkt);
    expect_ev(kind, pkt);
    send_bits(f, 16, -1);
    drive(1'b0, GAP_WAIT);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{enc(11'd1046, 1'b1), EV_VALID, 16'h82D7};
    vecs[1] = '{16'h82DF, EV_CRC,   16'h82D7};
    vecs[2] = '{16'h0000, EV_VALID, 16'h0000};
    vecs[3] = '{16'h1234, EV_CRC,   16'h0000};
    vecs[4] = '{16'h0606, EV_VALID, 16'h0606};
    vecs[5] = '{16'hFFFF, EV_VALID, 16'hFFFF};
    vecs[6] = '{16'h82DE, EV_CRC,   16'hFFFF};

    // Reset state.
    reset_n  = 1'b0;
    bus.rxIn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_packet", 32'(bus.packet), 32'h0);
    check("rst_command", 32'(bus.command), 32'h0);
    check("rst_tlm", 32'(bus.telemetryReq), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_crcError", 32'(bus.crcError), 32'h0);
    check("rst_frameError", 32'(bus.frameError), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    drive(1'b0, 40);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      $display("vector %0d frame=%04h", i, vecs[i].frame);
      send_frame(vecs[i].frame, vecs[i].kind, vecs[i].pkt);
    end

    // Partial frame: 9 bits then a long low.
    expect_ev(EV_FRAME, 16'hFFFF);
    send_bits(16'hA5A5, 9, -1);
    drive(1'b0, GAP_WAIT);
    send_frame(16'h0000, EV_VALID, 16'h0000);

    // Short spike inside bit 2's low phase.
    expect_ev(EV_VALID, 16'h0606);
    send_bits(16'h0606, 16, 2);
    drive(1'b0, GAP_WAIT);

    // Stuck-high line.
    expect_ev(EV_FRAME, 16'h0606);
    drive(1'b1, 2 * BITP);
    check("stuck_busy", 32'(bus.busy), 32'h0);
    drive(1'b0, GAP_WAIT);
    send_frame(16'h82D7, EV_VALID, 16'h82D7);

    // Back-to-back without a gap: only the first frame is decoded.
    expect_ev(EV_VALID, 16'h0000);
    send_bits(16'h0000, 16, -1);
    drive(1'b0, 4);
    send_bits(16'h0606, 16, -1);
    drive(1'b0, GAP_WAIT);
    check("b2b_packet", 32'(bus.packet), 32'h0000);

    // Reset asserted in bit 8.
    send_bits(16'hFFFF, 8, -1);
    drive(1'b1, 3);
    reset_n  = 1'b0;
    bus.rxIn = 1'b0;
    #1;
    check("midrst_packet", 32'(bus.packet), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    drive(1'b0, 2);
    reset_n = 1'b1;
    drive(1'b0, 40);
    send_frame(16'h82D7, EV_VALID, 16'h82D7);
    send_frame(16'h0606, EV_VALID, 16'h0606);
    send_frame(16'hFFFF, EV_VALID, 16'hFFFF);

    drive(1'b0, 20);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
